// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU operation sequencer: opcodes, FSM states,
// datapath flag positions and opcode classification helpers.
package alu_ctrl_pkg;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OP_CLR = 4'd0;
  localparam opcode_t OP_ADD = 4'd1;
  localparam opcode_t OP_SUB = 4'd2;
  localparam opcode_t OP_MUL = 4'd3;
  localparam opcode_t OP_DIV = 4'd4;
  localparam opcode_t OP_SHR = 4'd5;
  localparam opcode_t OP_SHL = 4'd6;
  localparam opcode_t OP_AND = 4'd7;
  localparam opcode_t OP_OR  = 4'd8;
  localparam opcode_t OP_NOT = 4'd9;

  // Strobe vector bit i belongs to opcode i: {C21,C20,C19,C18,C17,C16,C15,C13,C9,C8}
  localparam int N_STROBE = 10;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_EXEC    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_REPORT  = 3'd4
  } state_e;

  function automatic logic is_binary(opcode_t op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) ||
           (op == OP_DIV) || (op == OP_AND) || (op == OP_OR);
  endfunction

  function automatic logic is_legal(opcode_t op);
    return op <= OP_NOT;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/response channel between the microsequencer and the ALU op sequencer.
interface alu_op_if #(
  parameter int DATA_W = 16,
  parameter int FLAG_W = 4
);
  logic              op_valid;
  logic [3:0]        op_code;
  logic [DATA_W-1:0] operand;
  logic              op_ready;
  logic              done;
  logic [DATA_W-1:0] result;
  logic [FLAG_W-1:0] flags;
  logic              err;

  modport master (
    output op_valid, op_code, operand,
    input  op_ready, done, result, flags, err
  );

  modport slave (
    input  op_valid, op_code, operand,
    output op_ready, done, result, flags, err
  );
endinterface

// File: rtl/alu_strobe_decode.sv
// Opcode to one-hot datapath strobe vector; all-zero for illegal opcodes.
module alu_strobe_decode
  import alu_ctrl_pkg::*;
(
  input  opcode_t             op_code,
  output logic [N_STROBE-1:0] strobe
);

  always_comb begin
    strobe = '0;
    case (op_code)
      OP_CLR:  strobe[0] = 1'b1;
      OP_ADD:  strobe[1] = 1'b1;
      OP_SUB:  strobe[2] = 1'b1;
      OP_MUL:  strobe[3] = 1'b1;
      OP_DIV:  strobe[4] = 1'b1;
      OP_SHR:  strobe[5] = 1'b1;
      OP_SHL:  strobe[6] = 1'b1;
      OP_AND:  strobe[7] = 1'b1;
      OP_OR:   strobe[8] = 1'b1;
      OP_NOT:  strobe[9] = 1'b1;
      default: strobe = '0;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues one datapath strobe per accepted ALU operation and returns the
// captured accumulator/flags with a one-cycle done pulse.
//
//   state   | meaning
//   IDLE    | op_ready high, waiting for a request
//   CHECK   | reject illegal opcode or divide by zero
//   EXEC    | exactly one strobe high, datapath updates on closing edge
//   CAPTURE | sample ALU_out / ALUflags
//   REPORT  | done pulse with result, flags, err
module alu_op_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FLAG_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_op_if.slave           req,
  output logic [DATA_W-1:0] BR_out,
  output logic              C8,
  output logic              C9,
  output logic              C13,
  output logic              C15,
  output logic              C16,
  output logic              C17,
  output logic              C18,
  output logic              C19,
  output logic              C20,
  output logic              C21,
  input  logic [DATA_W-1:0] ALU_out,
  input  logic [FLAG_W-1:0] ALUflags
);

  state_e              state_q,    state_d;
  opcode_t             op_q,       op_d;
  logic [DATA_W-1:0]   br_q,       br_d;
  logic [N_STROBE-1:0] strobe_q,   strobe_d;
  logic                op_ready_q, op_ready_d;
  logic                done_q,     done_d;
  logic                err_q,      err_d;
  logic [DATA_W-1:0]   result_q,   result_d;
  logic [FLAG_W-1:0]   flags_q,    flags_d;
  logic [N_STROBE-1:0] dec_strobe;

  alu_strobe_decode u_decode (
    .op_code (op_q),
    .strobe  (dec_strobe)
  );

  // Outputs are registered one state ahead so they line up with state_q.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    br_d     = br_q;
    result_d = result_q;
    flags_d  = flags_q;
    strobe_d = '0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req.op_valid && op_ready_q) begin
          op_d    = req.op_code;
          state_d = ST_CHECK;
          if (is_binary(req.op_code)) br_d = req.operand;
        end
      end
      ST_CHECK: begin
        if (!is_legal(op_q) || (op_q == OP_DIV && br_q == '0)) begin
          state_d = ST_REPORT;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          state_d  = ST_EXEC;
          strobe_d = dec_strobe;
        end
      end
      ST_EXEC: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        result_d = ALU_out;
        flags_d  = ALUflags;
        state_d  = ST_REPORT;
        done_d   = 1'b1;
      end
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    op_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_CLR;
      br_q       <= '0;
      strobe_q   <= '0;
      op_ready_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      result_q   <= '0;
      flags_q    <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      br_q       <= br_d;
      strobe_q   <= strobe_d;
      op_ready_q <= op_ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
    end
  end

  assign BR_out = br_q;
  assign {C21, C20, C19, C18, C17, C16, C15, C13, C9, C8} = strobe_q;

  assign req.op_ready = op_ready_q;
  assign req.done     = done_q;
  assign req.err      = err_q;
  assign req.result   = result_q;
  assign req.flags    = flags_q;

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Control-side driver for the ALU/accumulator datapath. Accepts one ALU operation at a time over a valid/ready request interface and places the operand on BR_out. It issues exactly one single-cycle control strobe (C8, C9, C13, C15–C21), then captures ALU_out and ALUflags and returns them with a one-cycle done pulse. It sits between the instruction decode / microsequencer and the ALU_ACC datapath.

Parameters:
DATA_W, 16, width of operand, BR_out, ALU_out and result.
FLAG_W, 4, width of ALUflags and the captured flags.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
op_valid  in  1  requester has an operation pending.
op_code  in  4  operation select; encoding is given under Behaviour.
operand  in  DATA_W  operand for binary operations; ignored for unary operations.
op_ready  out  1  high only in IDLE; a request is accepted on a cycle with op_valid && op_ready.
BR_out  out  DATA_W  operand presented to the datapath; registered.
C8,C9,C13,C15,C16,C17,C18,C19,C20,C21  out  1 each  registered datapath strobes, one-hot or all-zero.
ALU_out  in  DATA_W  accumulator value from the datapath.
ALUflags  in  FLAG_W  datapath flags.
done  out  1  one-cycle pulse; result, flags and err are valid in that cycle.
result  out  DATA_W  captured accumulator value.
flags  out  FLAG_W  captured flags.
err  out  1  set together with done for a rejected operation.

Behaviour:
- Reset values:
  - op_ready=0 while rst_n=0, then 1 in IDLE.
  - All C strobes, done and err are 0; BR_out, result and flags are 0.
  - State is IDLE.
- Reset asserted mid-operation:
  - All strobes drop asynchronously.
  - No done pulse is produced for the aborted operation.
- Opcode encoding:
  - 0 CLR→C8, 1 ADD→C9, 2 SUB→C13, 3 MUL→C15, 4 DIV→C16.
  - 5 SHR→C17, 6 SHL→C18, 7 AND→C19, 8 OR→C20, 9 NOT→C21.
  - 10–15 are illegal.
- State machine:
  - IDLE: op_ready=1. On accept, latch op_code into the FSM. Load BR_out<=operand for binary operations (ADD, SUB, MUL, DIV, AND, OR). BR_out is left unchanged for unary operations. Go to CHECK.
  - CHECK: if op_code is illegal, or op_code is DIV with BR_out==0, go to REPORT with err=1. Otherwise go to EXEC.
  - EXEC: exactly one strobe is high for exactly this cycle. The datapath updates the accumulator on the closing edge. Go to CAPTURE.
  - CAPTURE: all strobes are 0. Sample result<=ALU_out and flags<=ALUflags. Go to REPORT with err=0.
  - REPORT: done=1 for one cycle. Return to IDLE.
- Latency:
  - Accept edge to done = 4 cycles for valid operations (CHECK, EXEC, CAPTURE, REPORT).
  - Accept edge to done = 2 cycles for rejected operations.
  - Back-to-back: the next accept can occur in the cycle after done. Minimum issue interval is 5 cycles.
- Rejected operations:
  - No strobe is asserted.
  - result and flags hold their previous values.
- BR_out stays stable from CHECK through CAPTURE. It holds its value until the next binary accept.
- op_valid while busy is ignored. The requester keeps op_valid and its op_code/operand stable until accepted; the block does not buffer them.
- Invariant: never more than one strobe high, in any cycle.

Decomposition:
- Shared package alu_ctrl_pkg:
  - opcode localparams OP_CLR..OP_NOT;
  - state encoding IDLE/CHECK/EXEC/CAPTURE/REPORT;
  - is_binary() function;
  - flag bit index constants.
- One sub-module, alu_strobe_decode: combinational opcode → 10-bit one-hot strobe vector, all-zero for illegal codes. The parent registers the vector in EXEC.

Test Plan:
1. After reset: CLR, then ADD 10, then ADD 5 → done after 4 cycles each. Results 0, 10, 15. Only C8/C9 pulse, one cycle each.
2. From 15: SUB 3, MUL 2, DIV 3 → results 12, 24, 8. BR_out equals the operand in the EXEC cycle.
3. From 8: SHR, SHL, AND 16'hFF00, OR 16'h00FF, NOT → results 4, 8, 0x0000, 0x00FF, 0xFF00. BR_out is unchanged across the unary operations.
4. DIV with operand 0 → done 2 cycles after accept with err=1. No C16 pulse; result stays at its prior value.
5. op_code 4'hF → err=1 and no strobe. op_valid held during a busy ADD is accepted only in the cycle after done.
6. rst_n asserted during EXEC → strobe low immediately, no done pulse. All outputs at reset values; op_ready=1 after release.
